hmmm_read_port: RTL and testbench

- Input side of the hmmm `read` instruction.
- Accepts words from an external host over a valid/ready stream and buffers them in a small FIFO.
- Serves them to the core through a level request / one-cycle acknowledge handshake, stalling the core while no word is available.
- Sits between the host I/O stream and the core's register-writeback path; the counterpart of the core's `write` output path.

---
 rtl/hmmm_read_port.sv | 101 ++++++++++
 tb/tb_hmmm_read_port.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/hmmm_read_port.sv
// Input side of the hmmm `read` instruction: buffers host words in a small FIFO
// and hands them to the core through a level request / one-cycle acknowledge.
module hmmm_read_port #(
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [W-1:0]                 in_data,
  output logic                         in_ready,
  input  logic                         rd_req,
  output logic                         rd_ack,
  output logic [W-1:0]                 rd_data,
  output logic                         stall,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   mem_q [DEPTH];
  logic [PW-1:0]  wptr_q, rptr_q;
  logic [CW-1:0]  count_q, count_d;
  logic [W-1:0]   rd_data_q;
  logic           push, pop, empty;

  assign empty    = (count_q == '0);
  assign in_ready = (count_q < CW'(DEPTH));
  assign push     = in_valid & in_ready;
  assign count_d  = count_q + CW'(push) - CW'(pop);

  assign rd_ack  = (state_q == ST_ACK);
  assign rd_data = rd_data_q;
  assign count   = count_q;
  assign stall   = ((state_q == ST_IDLE) & rd_req) | (state_q == ST_WAIT);

  // Request FSM: a pop only ever happens on the edge that enters ACK.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rd_req) begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = ST_ACK;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        // A dropped request aborts the wait without consuming a word.
        if (!rd_req) begin
          state_d = ST_IDLE;
        end else if (!empty) begin
          pop     = 1'b1;
          state_d = ST_ACK;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      rd_data_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (push) begin
        wptr_q <= wptr_q + PW'(1);
      end
      if (pop) begin
        rptr_q    <= rptr_q + PW'(1);
        rd_data_q <= mem_q[rptr_q];
      end
    end
  end

  // Storage needs no reset: occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem_q[wptr_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_hmmm_read_port.sv
// Bench for hmmm_read_port: directed vector table, FIFO-order wrap sequence and
// randomized traffic against a queue-based protocol model.
module tb_hmmm_read_port;

  localparam int unsigned W     = 16;
  localparam int unsigned DEPTH = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          in_ready;
  logic          rd_req;
  logic          rd_ack;
  logic [W-1:0]  rd_data;
  logic          stall;
  logic [1:0]    count;

  int n_tests = 0;
  int n_fail  = 0;

  hmmm_read_port #(.W(W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .rd_req   (rd_req),
    .rd_ack   (rd_ack),
    .rd_data  (rd_data),
    .stall    (stall),
    .count    (count)
  );

  always #5 clk = ~clk;

  // Reference model: the buffer as a queue plus "ack this cycle" and
  // "request outstanding from an earlier cycle" flags.
  logic [W-1:0] mq[$];
  bit           m_ack  = 1'b0;
  bit           m_wait = 1'b0;
  logic [W-1:0] m_data = '0;
  logic [W-1:0] eq[$];

  typedef struct {
    logic          rst;
    logic          v;
    logic [W-1:0]  d;
    logic          rq;
    int            cnt;
    logic          rdy;
    logic          stl;
    logic          ack;
    logic [W-1:0]  dat;
  } vec_t;

  vec_t vt[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic model_check(input string tag);
    check({tag, " count"},    32'(count),    32'(mq.size()));
    check({tag, " in_ready"}, 32'(in_ready), 32'(mq.size() < DEPTH));
    check({tag, " stall"},    32'(stall),    32'(m_wait | (!m_ack & rd_req)));
    check({tag, " rd_ack"},   32'(rd_ack),   32'(m_ack));
    check({tag, " rd_data"},  32'(rd_data),  32'(m_data));
  endtask

  // Advance the model across the coming rising edge using the applied inputs.
  task automatic model_update();
    int sz;
    bit can_push;
    if (reset) begin
      mq.delete();
      m_ack  = 1'b0;
      m_wait = 1'b0;
      m_data = '0;
    end else begin
      sz       = mq.size();
      can_push = (sz < DEPTH);
      if (m_ack) begin
        m_ack  = 1'b0;
        m_wait = 1'b0;
      end else if (rd_req) begin
        if (sz > 0) begin
          m_data = mq.pop_front();
          m_ack  = 1'b1;
          m_wait = 1'b0;
        end else begin
          m_wait = 1'b1;
        end
      end else begin
        m_wait = 1'b0;
      end
      if (in_valid && can_push) mq.push_back(in_data);
    end
  endtask

  // Apply inputs after the falling edge, compare against the model, then step it.
  task automatic tick(input logic rst, input logic v, input logic [W-1:0] d,
                      input logic rq, input string tag);
    @(negedge clk);
    reset    = rst;
    in_valid = v;
    in_data  = d;
    rd_req   = rq;
    #1;
    model_check(tag);
    model_update();
  endtask

  function automatic void add(input logic rst, input logic v, input logic [W-1:0] d,
                              input logic rq, input int cnt, input logic rdy,
                              input logic stl, input logic ack, input logic [W-1:0] dat);
    vt.push_back('{rst, v, d, rq, cnt, rdy, stl, ack, dat});
  endfunction

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    rd_req   = 1'b0;
    repeat (2) @(posedge clk);

    //  rst v  data      rq  cnt rdy stl ack rd_data
    add(0, 0, 16'h0000, 0,  0,  1,  0,  0, 16'h0000);  // reset state
    add(0, 1, 16'h0001, 0,  0,  1,  0,  0, 16'h0000);
    add(0, 1, 16'h0002, 0,  1,  1,  0,  0, 16'h0000);
    add(0, 1, 16'h0003, 0,  2,  0,  0,  0, 16'h0000);  // full: refused
    add(0, 0, 16'h0000, 0,  2,  0,  0,  0, 16'h0000);
    add(0, 0, 16'h0000, 1,  2,  0,  1,  0, 16'h0000);  // request, data buffered
    add(0, 0, 16'h0000, 0,  1,  1,  0,  1, 16'h0001);
    add(0, 0, 16'h0000, 1,  1,  1,  1,  0, 16'h0001);
    add(0, 0, 16'h0000, 0,  0,  1,  0,  1, 16'h0002);
    add(0, 0, 16'h0000, 0,  0,  1,  0,  0, 16'h0002);
    add(0, 0, 16'h0000, 1,  0,  1,  1,  0, 16'h0002);  // empty: wait
    add(0, 0, 16'h0000, 1,  0,  1,  1,  0, 16'h0002);
    add(0, 0, 16'h0000, 1,  0,  1,  1,  0, 16'h0002);
    add(0, 0, 16'h0000, 1,  0,  1,  1,  0, 16'h0002);
    add(0, 1, 16'hBEEF, 1,  0,  1,  1,  0, 16'h0002);  // push at edge M
    add(0, 0, 16'h0000, 1,  1,  1,  1,  0, 16'h0002);
    add(0, 0, 16'h0000, 0,  0,  1,  0,  1, 16'hBEEF);  // ack in M+2
    add(0, 0, 16'h0000, 1,  0,  1,  1,  0, 16'hBEEF);
    add(0, 0, 16'h0000, 1,  0,  1,  1,  0, 16'hBEEF);
    add(0, 0, 16'h0000, 0,  0,  1,  1,  0, 16'hBEEF);  // abort from wait
    add(0, 0, 16'h0000, 0,  0,  1,  0,  0, 16'hBEEF);
    add(0, 1, 16'h1234, 0,  0,  1,  0,  0, 16'hBEEF);
    add(0, 0, 16'h0000, 0,  1,  1,  0,  0, 16'hBEEF);
    add(0, 0, 16'h0000, 0,  1,  1,  0,  0, 16'hBEEF);
    add(0, 1, 16'h00AA, 1,  1,  1,  1,  0, 16'hBEEF);  // push + pop together
    add(0, 0, 16'h0000, 0,  1,  1,  0,  1, 16'h1234);
    add(0, 1, 16'h00BB, 0,  1,  1,  0,  0, 16'h1234);
    add(0, 1, 16'h00CC, 1,  2,  0,  1,  0, 16'h1234);  // pop while full
    add(0, 0, 16'h0000, 0,  1,  1,  0,  1, 16'h00AA);
    add(0, 1, 16'h00DD, 0,  1,  1,  0,  0, 16'h00AA);
    add(0, 0, 16'h0000, 1,  2,  0,  1,  0, 16'h00AA);
    add(1, 1, 16'h00EE, 0,  1,  1,  0,  1, 16'h00BB);  // reset during ack
    add(0, 0, 16'h0000, 0,  0,  1,  0,  0, 16'h0000);
    add(0, 0, 16'h0000, 1,  0,  1,  1,  0, 16'h0000);
    add(0, 0, 16'h0000, 1,  0,  1,  1,  0, 16'h0000);
    add(0, 1, 16'h5555, 1,  0,  1,  1,  0, 16'h0000);
    add(0, 0, 16'h0000, 1,  1,  1,  1,  0, 16'h0000);
    add(0, 0, 16'h0000, 0,  0,  1,  0,  1, 16'h5555);

    foreach (vt[i]) begin
      tick(vt[i].rst, vt[i].v, vt[i].d, vt[i].rq, $sformatf("model row%0d", i));
      check($sformatf("row%0d count", i),    32'(count),    32'(vt[i].cnt));
      check($sformatf("row%0d in_ready", i), 32'(in_ready), 32'(vt[i].rdy));
      check($sformatf("row%0d stall", i),    32'(stall),    32'(vt[i].stl));
      check($sformatf("row%0d rd_ack", i),   32'(rd_ack),   32'(vt[i].ack));
      check($sformatf("row%0d rd_data", i),  32'(rd_data),  32'(vt[i].dat));
    end

    // Six push/pop rounds with one word always in flight, wrapping the pointers.
    tick(0, 1, 16'h0A00, 0, "wrap pre");
    eq.push_back(16'h0A00);
    for (int r = 0; r < 6; r++) begin
      logic [W-1:0] w;
      logic [W-1:0] e;
      w = 16'h0A01 + W'(r);
      tick(0, 1, w, 1, $sformatf("wrap%0d req", r));
      eq.push_back(w);
      tick(0, 0, '0, 0, $sformatf("wrap%0d ack", r));
      e = eq.pop_front();
      check($sformatf("wrap%0d rd_ack", r),  32'(rd_ack),  32'd1);
      check($sformatf("wrap%0d rd_data", r), 32'(rd_data), 32'(e));
      check($sformatf("wrap%0d count", r),   32'(count),   32'd1);
    end
    tick(0, 0, '0, 1, "wrap drain req");
    tick(0, 0, '0, 0, "wrap drain ack");
    check("wrap drain rd_data", 32'(rd_data), 32'(eq.pop_front()));
    check("wrap drain count",   32'(count),   32'd0);

    // Randomized host and core traffic, with occasional resets.
    for (int c = 0; c < 2000; c++) begin
      tick(($urandom_range(63) == 0), ($urandom_range(1) == 1), W'($urandom),
           ($urandom_range(9) < 6), $sformatf("rand%0d", c));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
